ex_mem_stage: RTL and testbench

Execute stage plus EX/MEM pipeline register of the 32-bit MIPS pipeline. It consumes the ID/EX register outputs: operands, PC+4, sign-extended immediate, register specifiers, control bits and 3-bit ALU opcode. It computes the ALU result, branch target and destination register, and registers them with the MEM/WB control bits for the memory stage. An optional iterative multiplier stalls upstream while it runs.

---
 rtl/ex_mem_stage.sv | 166 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM register: ALU, branch target, destination select.
// Optional iterative shift-add multiplier built when EX_MULT_EN is defined.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] SA,
  input  logic [31:0] SB,
  input  logic [31:0] SFetch,
  input  logic [31:0] SJump,
  input  logic [4:0]  SRD,
  input  logic [4:0]  SRT,
  input  logic        SRegDst,
  input  logic        SBranch,
  input  logic        SMemRead,
  input  logic        SMemtoReg,
  input  logic        SMemWrite,
  input  logic        SALUSrc,
  input  logic        SRegWrite,
  input  logic [2:0]  SALUOP,
  input  logic        Flush,
  output logic        Stall,
  output logic [31:0] MALURes,
  output logic [31:0] MWriteData,
  output logic [31:0] MBranchTarget,
  output logic        MZero,
  output logic [4:0]  MWriteReg,
  output logic        MBranch,
  output logic        MMemRead,
  output logic        MMemtoReg,
  output logic        MMemWrite,
  output logic        MRegWrite
);

  logic [31:0] w_opb;
  logic [31:0] w_alu;
  logic [31:0] w_target;
  logic [4:0]  w_wreg;
  logic        w_load_live;
  logic        w_load_prod;
  logic [31:0] w_prod;
  logic [4:0]  w_prod_ctl;
  logic [4:0]  w_prod_wreg;

  assign w_opb    = SALUSrc ? SJump : SB;
  assign w_target = SFetch + {SJump[29:0], 2'b00};
  assign w_wreg   = SRegDst ? SRD : SRT;

  always_comb begin
    w_alu = 32'd0;
    case (SALUOP)
      3'b000:  w_alu = SA & w_opb;
      3'b001:  w_alu = SA | w_opb;
      3'b010:  w_alu = SA + w_opb;
      3'b011:  w_alu = SA - w_opb;
      3'b100:  w_alu = {31'd0, ($signed(SA) < $signed(w_opb))};
      3'b101:  w_alu = ~(SA | w_opb);
      3'b110:  w_alu = SA ^ w_opb;
      default: w_alu = w_opb;  // MUL slot acts as a move of operand B when no multiplier
    endcase
  end

`ifdef EX_MULT_EN
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_ctl;
  logic [4:0]  r_wreg;
  logic        w_is_mul;

  assign w_is_mul    = (SALUOP == 3'b111);
  assign Stall       = !rst && !Flush &&
                       (((r_state == S_IDLE) && w_is_mul) || (r_state == S_MUL));
  assign w_load_live = (r_state == S_IDLE) && !Flush && !w_is_mul;
  assign w_load_prod = (r_state == S_DONE) && !Flush;
  assign w_prod      = r_acc;
  assign w_prod_ctl  = r_ctl;
  assign w_prod_wreg = r_wreg;

  // Multiplicand shifts left, multiplier shifts right; one partial product per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_acc   <= 32'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_ctl   <= 5'd0;
      r_wreg  <= 5'd0;
    end else if (Flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_acc   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mul) begin
            r_a     <= SA;
            r_b     <= w_opb;
            r_ctl   <= {SBranch, SMemRead, SMemtoReg, SMemWrite, SRegWrite};
            r_wreg  <= w_wreg;
            r_acc   <= 32'd0;
            r_cnt   <= 5'd0;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          if (r_b[0]) r_acc <= r_acc + r_a;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign Stall       = 1'b0;
  assign w_load_live = !Flush;
  assign w_load_prod = 1'b0;
  assign w_prod      = 32'd0;
  assign w_prod_ctl  = 5'd0;
  assign w_prod_wreg = 5'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      MALURes       <= 32'd0;
      MWriteData    <= 32'd0;
      MBranchTarget <= 32'd0;
      MZero         <= 1'b0;
      MWriteReg     <= 5'd0;
      {MBranch, MMemRead, MMemtoReg, MMemWrite, MRegWrite} <= 5'd0;
    end else if (w_load_live) begin
      MALURes       <= w_alu;
      MWriteData    <= SB;
      MBranchTarget <= w_target;
      MZero         <= (w_alu == 32'd0);
      MWriteReg     <= w_wreg;
      {MBranch, MMemRead, MMemtoReg, MMemWrite, MRegWrite} <=
        {SBranch, SMemRead, SMemtoReg, SMemWrite, SRegWrite};
    end else if (w_load_prod) begin
      MALURes       <= w_prod;
      MWriteData    <= 32'd0;
      MBranchTarget <= 32'd0;
      MZero         <= (w_prod == 32'd0);
      MWriteReg     <= w_prod_wreg;
      {MBranch, MMemRead, MMemtoReg, MMemWrite, MRegWrite} <= w_prod_ctl;
    end else begin
      MALURes       <= 32'd0;
      MWriteData    <= 32'd0;
      MBranchTarget <= 32'd0;
      MZero         <= 1'b0;
      MWriteReg     <= 5'd0;
      {MBranch, MMemRead, MMemtoReg, MMemWrite, MRegWrite} <= 5'd0;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage; multiplier scenarios run when EX_MULT_EN is defined.
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] SA, SB, SFetch, SJump;
  logic [4:0]  SRD, SRT;
  logic        SRegDst, SBranch, SMemRead, SMemtoReg, SMemWrite, SALUSrc, SRegWrite;
  logic [2:0]  SALUOP;
  logic        Flush;
  logic        Stall;
  logic [31:0] MALURes, MWriteData, MBranchTarget;
  logic        MZero;
  logic [4:0]  MWriteReg;
  logic        MBranch, MMemRead, MMemtoReg, MMemWrite, MRegWrite;

  int errors = 0;
  int checks = 0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .SA(SA), .SB(SB), .SFetch(SFetch), .SJump(SJump),
    .SRD(SRD), .SRT(SRT), .SRegDst(SRegDst), .SBranch(SBranch), .SMemRead(SMemRead),
    .SMemtoReg(SMemtoReg), .SMemWrite(SMemWrite), .SALUSrc(SALUSrc), .SRegWrite(SRegWrite),
    .SALUOP(SALUOP), .Flush(Flush), .Stall(Stall), .MALURes(MALURes),
    .MWriteData(MWriteData), .MBranchTarget(MBranchTarget), .MZero(MZero),
    .MWriteReg(MWriteReg), .MBranch(MBranch), .MMemRead(MMemRead), .MMemtoReg(MMemtoReg),
    .MMemWrite(MMemWrite), .MRegWrite(MRegWrite)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    SA = 0; SB = 0; SFetch = 0; SJump = 0; SRD = 0; SRT = 0;
    SRegDst = 0; SBranch = 0; SMemRead = 0; SMemtoReg = 0; SMemWrite = 0;
    SALUSrc = 0; SRegWrite = 0; SALUOP = 3'b010; Flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    SA = 32'd10; SB = 32'd20; SRegWrite = 1; SMemRead = 1; SRegDst = 1; SRD = 5'd3;
    SFetch = 32'h40; SJump = 32'h4;
    step(); step();
    checks++;
    if ({MALURes, MWriteData, MBranchTarget} !== 96'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h want 0", MALURes, MWriteData, MBranchTarget);
    end
    checks++;
    if ({MZero, MWriteReg, MBranch, MMemRead, MMemtoReg, MMemWrite, MRegWrite, Stall} !== 12'd0) begin
      errors++; $display("FAIL reset_ctl: got %b want 0",
        {MZero, MWriteReg, MBranch, MMemRead, MMemtoReg, MMemWrite, MRegWrite, Stall});
    end
    rst = 0;
    step();
    checks++;
    if (MALURes !== 32'd30 || MRegWrite !== 1'b1 || MMemRead !== 1'b1 || MWriteReg !== 5'd3
        || MBranchTarget !== 32'h50 || MWriteData !== 32'd20) begin
      errors++; $display("FAIL reset_release: got res=%h rw=%b mr=%b wr=%0d bt=%h wd=%h want 1e 1 1 3 50 14",
        MALURes, MRegWrite, MMemRead, MWriteReg, MBranchTarget, MWriteData);
    end
  endtask

  task automatic test_add();
    clear_inputs();
    SALUOP = 3'b010; SA = 32'h7FFFFFFF; SB = 32'd1; SRegDst = 1; SRD = 5'd5; SRT = 5'd9; SRegWrite = 1;
    step();
    checks++;
    if (MALURes !== 32'h80000000 || MWriteReg !== 5'd5 || MZero !== 1'b0 || MRegWrite !== 1'b1) begin
      errors++; $display("FAIL add: got res=%h wr=%0d z=%b rw=%b want 80000000 5 0 1",
        MALURes, MWriteReg, MZero, MRegWrite);
    end
  endtask

  task automatic test_sub_branch();
    clear_inputs();
    SALUOP = 3'b011; SA = 32'h1234; SB = 32'h1234; SBranch = 1; SFetch = 32'h100;
    SJump = 32'hFFFFFFFF; SRT = 5'd7;
    step();
    checks++;
    if (MALURes !== 32'd0 || MZero !== 1'b1 || MBranchTarget !== 32'hFC || MBranch !== 1'b1 || MWriteReg !== 5'd7) begin
      errors++; $display("FAIL sub_branch: got res=%h z=%b bt=%h br=%b wr=%0d want 0 1 fc 1 7",
        MALURes, MZero, MBranchTarget, MBranch, MWriteReg);
    end
  endtask

  task automatic test_logic_ops();
    logic [2:0]  ops  [5] = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b101};
    logic [31:0] want [5] = '{32'd1, 32'h0FF00FF0, 32'hF000F000, 32'hFFF0FFF0, 32'h000F000F};
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      SALUOP = ops[i];
      if (i == 0) begin
        SA = 32'hFFFFFFFF; SJump = 32'd1; SALUSrc = 1; SB = 32'h0;
      end else begin
        SA = 32'hF0F0F0F0; SB = 32'hFF00FF00;
      end
      step();
      checks++;
      if (MALURes !== want[i] || MZero !== 1'b0) begin
        errors++; $display("FAIL logic_op%0d: got res=%h z=%b want %h 0", ops[i], MALURes, MZero, want[i]);
      end
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    SA = 32'd4; SB = 32'd6; SRegWrite = 1; SMemWrite = 1; SBranch = 1; SRegDst = 1; SRD = 5'd2;
    Flush = 1;
    step();
    checks++;
    if ({MBranch, MMemRead, MMemtoReg, MMemWrite, MRegWrite} !== 5'd0 || MALURes !== 32'd0 || MWriteReg !== 5'd0) begin
      errors++; $display("FAIL flush_bubble: got ctl=%b res=%h wr=%0d want 0 0 0",
        {MBranch, MMemRead, MMemtoReg, MMemWrite, MRegWrite}, MALURes, MWriteReg);
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    SA = 32'd100; SB = 32'd1; SALUOP = 3'b011; SMemtoReg = 1; SRegWrite = 1;
    step();
    checks++;
    if (MALURes !== 32'd99 || MMemtoReg !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got res=%h mtr=%b want 63 1", MALURes, MMemtoReg);
    end
    SA = 32'hFFFFFFFF; SB = 32'd1; SALUOP = 3'b010; SMemtoReg = 0;
    step();
    checks++;
    if (MALURes !== 32'd0 || MZero !== 1'b1 || MMemtoReg !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got res=%h z=%b mtr=%b want 0 1 0", MALURes, MZero, MMemtoReg);
    end
  endtask

`ifndef EX_MULT_EN
  task automatic test_mul_pass();
    clear_inputs();
    SALUOP = 3'b111; SA = 32'h5; SB = 32'h1234; SRegWrite = 1;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL mulpass_stall: got %b want 0", Stall);
    end
    step();
    checks++;
    if (MALURes !== 32'h1234 || MRegWrite !== 1'b1) begin
      errors++; $display("FAIL mulpass_res: got res=%h rw=%b want 1234 1", MALURes, MRegWrite);
    end
  endtask
`else
  task automatic test_mul();
    int bad_stall;
    int bad_bubble;
    clear_inputs();
    SALUOP = 3'b111; SA = 32'h00010003; SB = 32'h00020005; SRegWrite = 1; SRegDst = 1; SRD = 5'd9;
    #1;
    bad_stall = (Stall !== 1'b1) ? 1 : 0;
    bad_bubble = 0;
    for (int k = 1; k <= 33; k++) begin
      step();
      if (k <= 32 && Stall !== 1'b1) bad_stall++;
      if (k == 33 && Stall !== 1'b0) bad_stall++;
      if (MRegWrite !== 1'b0 || MALURes !== 32'd0) bad_bubble++;
    end
    checks++;
    if (bad_stall != 0) begin
      errors++; $display("FAIL mul_stall: %0d cycles with wrong Stall, want 0", bad_stall);
    end
    checks++;
    if (bad_bubble != 0) begin
      errors++; $display("FAIL mul_bubble: %0d non-bubble cycles, want 0", bad_bubble);
    end
    step();
    checks++;
    if (MALURes !== 32'h000B000F || MRegWrite !== 1'b1 || MZero !== 1'b0 || MWriteReg !== 5'd9) begin
      errors++; $display("FAIL mul_product: got res=%h rw=%b z=%b wr=%0d want 000b000f 1 0 9",
        MALURes, MRegWrite, MZero, MWriteReg);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_mul_flush();
    int bad;
    clear_inputs();
    SALUOP = 3'b111; SA = 32'h00010003; SB = 32'h00020005; SRegWrite = 1;
    for (int k = 1; k <= 10; k++) step();
    Flush = 1;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL mulflush_stall: got %b want 0", Stall);
    end
    step();
    checks++;
    if (MRegWrite !== 1'b0 || MALURes !== 32'd0) begin
      errors++; $display("FAIL mulflush_bubble: got rw=%b res=%h want 0 0", MRegWrite, MALURes);
    end
    clear_inputs();
    SALUOP = 3'b010; SA = 32'd2; SB = 32'd3; SRegWrite = 1;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL mulflush_idle: got Stall %b want 0", Stall);
    end
    step();
    checks++;
    if (MALURes !== 32'd5 || MRegWrite !== 1'b1) begin
      errors++; $display("FAIL mulflush_add: got res=%h rw=%b want 5 1", MALURes, MRegWrite);
    end
    clear_inputs();
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (MRegWrite !== 1'b0 || MALURes === 32'h000B000F || Stall !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mulflush_noproduct: %0d bad cycles want 0", bad);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub_branch();
    test_logic_ops();
    test_flush();
    test_back_to_back();
`ifdef EX_MULT_EN
    test_mul();
    test_mul_flush();
`else
    test_mul_pass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
